pcs_40g_rx_am_lock: RTL

//  Per-lane receive alignment-marker (AM) lock for the 40GBASE-R PCS RX path. It sits after block sync and before lane deskew/reorder.
//  It finds the periodic AM in the lane's 66b block stream and identifies which PCS lane (0..3) the stream carries.

---
 rtl/pcs_40g_pkg.sv | 31 +++
 rtl/pcs_40g_am_match.sv | 43 ++++
 rtl/pcs_40g_rx_am_lock.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pcs_40g_pkg.sv
// Shared 40GBASE-R PCS definitions: control sync header, per-lane alignment marker table
// and the RX AM lock state encoding.
package pcs_40g_pkg;

    localparam logic [1:0] SYNC_HEAD_CTRL = 2'b10;
    localparam int unsigned AM_LANES = 4;

    // Fixed AM bytes; BIP3/BIP7 carry parity and are not part of the match.
    typedef struct packed {
        logic [7:0] m0;
        logic [7:0] m1;
        logic [7:0] m2;
        logic [7:0] m4;
        logic [7:0] m5;
        logic [7:0] m6;
    } am_lane_t;

    localparam am_lane_t [0:AM_LANES-1] AM_LUT = '{
        '{8'h90, 8'h76, 8'h47, 8'h6F, 8'h89, 8'hB8},
        '{8'hF0, 8'hC4, 8'hE6, 8'h0F, 8'h3B, 8'h19},
        '{8'hC5, 8'h65, 8'h9B, 8'h3A, 8'h9A, 8'h64},
        '{8'hA2, 8'h79, 8'h3D, 8'h5D, 8'h86, 8'hC2}
    };

    typedef enum logic [1:0] {
        StInit,
        StGet2nd,
        StLock
    } am_lock_fsm_e;

endpackage

// File: rtl/pcs_40g_am_match.sv
// Combinational alignment-marker detector: flags a valid control block whose fixed AM bytes
// equal one lane's table entry and reports that lane (lowest index on a tie).
module pcs_40g_am_match
    import pcs_40g_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned HEAD_W = 2,
    parameter int unsigned LANE_N = 4
) (
    input  logic                      valid_i,
    input  logic [HEAD_W-1:0]         head_i,
    input  logic [DATA_W-1:0]         data_i,
    output logic                      match_v,
    output logic [$clog2(LANE_N)-1:0] match_id
);

    localparam int unsigned ID_W = $clog2(LANE_N);

    am_lane_t rx_am;
    logic     is_ctrl;

    assign rx_am = '{
        m0: data_i[7:0],
        m1: data_i[15:8],
        m2: data_i[23:16],
        m4: data_i[39:32],
        m5: data_i[47:40],
        m6: data_i[55:48]
    };
    assign is_ctrl = valid_i && (head_i == SYNC_HEAD_CTRL);

    always_comb begin
        match_v  = 1'b0;
        match_id = '0;
        for (int unsigned i = 0; i < LANE_N; i++) begin
            if (!match_v && is_ctrl && (rx_am == AM_LUT[i])) begin
                match_v  = 1'b1;
                match_id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/pcs_40g_rx_am_lock.sv
// Per-lane RX alignment-marker lock: finds the periodic AM, identifies the PCS lane and
// passes the block stream through one register stage with AM blocks flagged.
module pcs_40g_rx_am_lock
    import pcs_40g_pkg::*;
#(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned HEAD_W   = 2,
    parameter int unsigned AM_GAP   = 16384,
    parameter int unsigned AM_INV_N = 4,
    parameter int unsigned LANE_N   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      lock_v_i,
    input  logic                      valid_i,
    input  logic [HEAD_W-1:0]         head_i,
    input  logic [DATA_W-1:0]         data_i,
    output logic                      valid_o,
    output logic [HEAD_W-1:0]         head_o,
    output logic [DATA_W-1:0]         data_o,
    output logic                      am_v_o,
    output logic                      am_lock_o,
    output logic [$clog2(LANE_N)-1:0] lane_id_o
);

    localparam int unsigned CNT_W = $clog2(AM_GAP);
    localparam int unsigned ID_W  = $clog2(LANE_N);
    localparam int unsigned INV_W = $clog2(AM_INV_N + 1);

    am_lock_fsm_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [INV_W-1:0] inv_q;
    logic [ID_W-1:0]  id_q;
    logic             match_v;
    logic [ID_W-1:0]  match_id;
    logic             slot;
    logic             id_hit;

    pcs_40g_am_match #(
        .DATA_W (DATA_W),
        .HEAD_W (HEAD_W),
        .LANE_N (LANE_N)
    ) u_am_match (
        .valid_i  (valid_i),
        .head_i   (head_i),
        .data_i   (data_i),
        .match_v  (match_v),
        .match_id (match_id)
    );

    assign cnt_nxt = (cnt_q == CNT_W'(AM_GAP - 1)) ? '0 : cnt_q + CNT_W'(1);
    assign slot    = (cnt_q == '0);
    assign id_hit  = match_v && (match_id == id_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StInit;
            cnt_q     <= '0;
            inv_q     <= '0;
            id_q      <= '0;
            valid_o   <= 1'b0;
            head_o    <= '0;
            data_o    <= '0;
            am_v_o    <= 1'b0;
            am_lock_o <= 1'b0;
            lane_id_o <= '0;
        end else begin
            valid_o <= valid_i;
            head_o  <= head_i;
            data_o  <= data_i;
            am_v_o  <= 1'b0;
            // Losing block lock overrides everything, even an AM arriving in this cycle.
            if (!lock_v_i) begin
                state_q   <= StInit;
                cnt_q     <= '0;
                inv_q     <= '0;
                am_lock_o <= 1'b0;
            end else if (valid_i) begin
                cnt_q <= cnt_nxt;
                unique case (state_q)
                    StInit: begin
                        if (match_v) begin
                            id_q    <= match_id;
                            cnt_q   <= CNT_W'(1);
                            state_q <= StGet2nd;
                        end
                    end
                    StGet2nd: begin
                        if (slot) begin
                            if (id_hit) begin
                                state_q   <= StLock;
                                inv_q     <= '0;
                                am_v_o    <= 1'b1;
                                am_lock_o <= 1'b1;
                                lane_id_o <= id_q;
                            end else begin
                                state_q <= StInit;
                            end
                        end
                    end
                    StLock: begin
                        if (slot) begin
                            am_v_o <= 1'b1;
                            if (id_hit) begin
                                inv_q <= '0;
                            end else if (inv_q == INV_W'(AM_INV_N - 1)) begin
                                state_q   <= StInit;
                                inv_q     <= '0;
                                am_lock_o <= 1'b0;
                            end else begin
                                inv_q <= inv_q + INV_W'(1);
                            end
                        end
                    end
                    default: state_q <= StInit;
                endcase
            end
        end
    end

endmodule
